// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam int MEM_WORDS_DEF = 2048;
    localparam int LD_CNT_W_DEF  = 12;
    localparam int ADDR_W        = 13;

endpackage

// File: rtl/fetch_loader.sv
// Boot loader datapath: word counter, byte address generation and the
// sticky overflow flag. Only active while i_en is high (FSM in LOAD).
module fetch_loader
    import fetch_ctrl_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int LD_CNT_W  = LD_CNT_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_ld_valid,
    input  logic [31:0]         i_ld_data,
    input  logic                i_ld_last,
    output logic                o_ld_ready,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [31:0]         o_mem_wdata,
    output logic [LD_CNT_W-1:0] o_ld_count,
    output logic                o_ld_ovf,
    output logic                o_done
);

    logic [LD_CNT_W-1:0] r_count;
    logic                r_ovf;
    logic                w_xfer;
    logic                w_at_cap;
    logic [LD_CNT_W+1:0] w_byte_addr;

    assign w_xfer      = i_en & i_ld_valid;
    assign w_at_cap    = (r_count == LD_CNT_W'(MEM_WORDS - 1));
    assign w_byte_addr = {r_count, 2'b00};

    assign o_ld_ready  = i_en;
    assign o_mem_we    = w_xfer;
    assign o_mem_addr  = ADDR_W'(w_byte_addr);
    // Gated so the write data bus reads zero whenever no write is happening.
    assign o_mem_wdata = w_xfer ? i_ld_data : 32'd0;
    assign o_ld_count  = r_count;
    assign o_ld_ovf    = r_ovf;
    // Image complete: explicit last word, or memory just filled up.
    assign o_done      = w_xfer & (i_ld_last | w_at_cap);

    // Word counter and sticky overflow (full memory without a last marker).
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_xfer) begin
            r_count <= r_count + 1'b1;
            if (w_at_cap && !i_ld_last) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: boot load sequencing and run/halt control.
// Optional boot loader enabled by defining FETCH_CTRL_BOOTLOAD_EN; without
// it IDLE goes straight to RUN and the loader outputs stay at zero.
//
// state | meaning
// IDLE  | one cycle after reset release
// LOAD  | accepting loader words into instruction memory
// RUN   | fetching; PC advances unless stalled or halting
// HALT  | fetch suppressed until i_resume
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int LD_CNT_W  = LD_CNT_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_ld_valid,
    input  logic [31:0]         i_ld_data,
    input  logic                i_ld_last,
    output logic                o_ld_ready,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [31:0]         o_mem_wdata,
    input  logic                i_stall,
    input  logic                i_halt,
    input  logic                i_resume,
    output logic                o_pc_en,
    output logic                o_fetch_valid,
    output logic [1:0]          o_state,
    output logic [LD_CNT_W-1:0] o_ld_count,
    output logic                o_ld_ovf
);

    state_t r_state;
    state_t w_next_state;
    logic   w_load_en;
    logic   w_ld_done;

`ifdef FETCH_CTRL_BOOTLOAD_EN
    assign w_load_en = (r_state == ST_LOAD);
`else
    assign w_load_en = 1'b0;
`endif

    fetch_loader #(
        .MEM_WORDS (MEM_WORDS),
        .LD_CNT_W  (LD_CNT_W)
    ) u_loader (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (w_load_en),
        .i_ld_valid  (i_ld_valid),
        .i_ld_data   (i_ld_data),
        .i_ld_last   (i_ld_last),
        .o_ld_ready  (o_ld_ready),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_ld_count  (o_ld_count),
        .o_ld_ovf    (o_ld_ovf),
        .o_done      (w_ld_done)
    );

    assign o_state = r_state;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and run/halt outputs; halt overrides stall on o_pc_en.
    always_comb begin
        w_next_state  = r_state;
        o_pc_en       = 1'b0;
        o_fetch_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
`ifdef FETCH_CTRL_BOOTLOAD_EN
                w_next_state = ST_LOAD;
`else
                w_next_state = ST_RUN;
`endif
            end
            ST_LOAD: begin
                if (w_ld_done) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                o_fetch_valid = 1'b1;
                o_pc_en       = ~i_stall & ~i_halt;
                if (i_halt) begin
                    w_next_state = ST_HALT;
                end
            end
            ST_HALT: begin
                if (i_resume) begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: run/halt vector table, standalone loader
// vector table, async reset, and boot-load sequences when
// FETCH_CTRL_BOOTLOAD_EN is defined.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        stall;
    logic        halt;
    logic        resume;

    logic        ld_ready;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        pc_en;
    logic        fetch_valid;
    logic [1:0]  state;
    logic [11:0] ld_count;
    logic        ld_ovf;

    logic        ldr_en;
    logic        ldr_valid;
    logic [31:0] ldr_data;
    logic        ldr_last;
    logic        ldr_ready;
    logic        ldr_we;
    logic [12:0] ldr_addr;
    logic [31:0] ldr_wdata;
    logic [2:0]  ldr_count;
    logic        ldr_ovf;
    logic        ldr_done;

    int n_checks = 0;
    int n_errors = 0;

    fetch_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_ld_valid    (ld_valid),
        .i_ld_data     (ld_data),
        .i_ld_last     (ld_last),
        .o_ld_ready    (ld_ready),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_stall       (stall),
        .i_halt        (halt),
        .i_resume      (resume),
        .o_pc_en       (pc_en),
        .o_fetch_valid (fetch_valid),
        .o_state       (state),
        .o_ld_count    (ld_count),
        .o_ld_ovf      (ld_ovf)
    );

`ifdef FETCH_CTRL_BOOTLOAD_EN
    logic        ld_ready4;
    logic        mem_we4;
    logic [12:0] mem_addr4;
    logic [31:0] mem_wdata4;
    logic        pc_en4;
    logic        fetch_valid4;
    logic [1:0]  state4;
    logic [2:0]  ld_count4;
    logic        ld_ovf4;

    fetch_ctrl #(.MEM_WORDS(4), .LD_CNT_W(3)) dut4 (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_ld_valid    (ld_valid),
        .i_ld_data     (ld_data),
        .i_ld_last     (ld_last),
        .o_ld_ready    (ld_ready4),
        .o_mem_we      (mem_we4),
        .o_mem_addr    (mem_addr4),
        .o_mem_wdata   (mem_wdata4),
        .i_stall       (stall),
        .i_halt        (halt),
        .i_resume      (resume),
        .o_pc_en       (pc_en4),
        .o_fetch_valid (fetch_valid4),
        .o_state       (state4),
        .o_ld_count    (ld_count4),
        .o_ld_ovf      (ld_ovf4)
    );
`endif

    fetch_loader #(.MEM_WORDS(4), .LD_CNT_W(3)) u_ldr (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_en        (ldr_en),
        .i_ld_valid  (ldr_valid),
        .i_ld_data   (ldr_data),
        .i_ld_last   (ldr_last),
        .o_ld_ready  (ldr_ready),
        .o_mem_we    (ldr_we),
        .o_mem_addr  (ldr_addr),
        .o_mem_wdata (ldr_wdata),
        .o_ld_count  (ldr_count),
        .o_ld_ovf    (ldr_ovf),
        .o_done      (ldr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       stall;
        logic       halt;
        logic       resume;
        logic [1:0] exp_state;
        logic       exp_pc_en;
        logic       exp_fv;
    } run_vec_t;

    typedef struct packed {
        logic        en;
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        exp_we;
        logic [12:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [2:0]  exp_cnt;
        logic        exp_done;
        logic        exp_ovf;
    } ldr_vec_t;

    run_vec_t run_vec [11];
    ldr_vec_t ldr_vec [8];
    logic [31:0] img [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 32'd0;
        ld_last  = 1'b0;
        stall    = 1'b0;
        halt     = 1'b0;
        resume   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // stall halt resume | state pc_en fetch_valid  (starting in RUN)
        run_vec[0]  = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1};
        run_vec[1]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1};
        run_vec[2]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1};
        run_vec[3]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1};
        run_vec[4]  = '{1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
        run_vec[5]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0};
        run_vec[6]  = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0};
        run_vec[7]  = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1};
        run_vec[8]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1};
        run_vec[9]  = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0};
        run_vec[10] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1};

        // en valid data last | we addr wdata count done ovf  (MEM_WORDS = 4)
        ldr_vec[0] = '{1'b1, 1'b1, 32'hAAAA0000, 1'b0, 1'b1, 13'h000, 32'hAAAA0000, 3'd0, 1'b0, 1'b0};
        ldr_vec[1] = '{1'b1, 1'b0, 32'hBBBB0001, 1'b0, 1'b0, 13'h004, 32'h00000000, 3'd1, 1'b0, 1'b0};
        ldr_vec[2] = '{1'b1, 1'b1, 32'hBBBB0001, 1'b0, 1'b1, 13'h004, 32'hBBBB0001, 3'd1, 1'b0, 1'b0};
        ldr_vec[3] = '{1'b1, 1'b0, 32'h12345678, 1'b1, 1'b0, 13'h008, 32'h00000000, 3'd2, 1'b0, 1'b0};
        ldr_vec[4] = '{1'b1, 1'b1, 32'hCCCC0002, 1'b0, 1'b1, 13'h008, 32'hCCCC0002, 3'd2, 1'b0, 1'b0};
        ldr_vec[5] = '{1'b1, 1'b1, 32'hDDDD0003, 1'b0, 1'b1, 13'h00C, 32'hDDDD0003, 3'd3, 1'b1, 1'b0};
        ldr_vec[6] = '{1'b0, 1'b1, 32'hEEEE0004, 1'b0, 1'b0, 13'h010, 32'h00000000, 3'd4, 1'b0, 1'b1};
        ldr_vec[7] = '{1'b0, 1'b1, 32'hFFFF0005, 1'b1, 1'b0, 13'h010, 32'h00000000, 3'd4, 1'b0, 1'b1};

        img[0] = 32'h00000013;
        img[1] = 32'h00100093;
        img[2] = 32'h00000073;
        img[3] = 32'h00208113;

        ldr_en = 1'b0; ldr_valid = 1'b0; ldr_data = 32'd0; ldr_last = 1'b0;

        do_reset();
        #1;
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_ready", 32'(ld_ready), 32'd0);
        chk("idle_pc_en", 32'(pc_en), 32'd0);
        chk("idle_fv", 32'(fetch_valid), 32'd0);
        @(negedge clk);

`ifdef FETCH_CTRL_BOOTLOAD_EN
        #1;
        chk("load_state", 32'(state), 32'd1);
        chk("load_ready", 32'(ld_ready), 32'd1);
        chk("load_we_idle", 32'(mem_we), 32'd0);
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = img[i];
            ld_last  = (i == 2);
            #1;
            chk("ld3_we", 32'(mem_we), 32'd1);
            chk("ld3_addr", 32'(mem_addr), 32'(i * 4));
            chk("ld3_wdata", mem_wdata, img[i]);
            chk("ld3_state", 32'(state), 32'd1);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
        chk("ld3_run", 32'(state), 32'd2);
        chk("ld3_count", 32'(ld_count), 32'd3);
        chk("ld3_ready_off", 32'(ld_ready), 32'd0);
        chk("ld3_ovf", 32'(ld_ovf), 32'd0);
`else
        #1;
        chk("noboot_run", 32'(state), 32'd2);
        chk("noboot_ready", 32'(ld_ready), 32'd0);
        chk("noboot_we", 32'(mem_we), 32'd0);
        ld_valid = 1'b1;
        ld_data  = 32'h13;
        ld_last  = 1'b1;
        @(negedge clk);
        #1;
        chk("noboot_state_hold", 32'(state), 32'd2);
        chk("noboot_ready2", 32'(ld_ready), 32'd0);
        chk("noboot_we2", 32'(mem_we), 32'd0);
        chk("noboot_count", 32'(ld_count), 32'd0);
        chk("noboot_ovf", 32'(ld_ovf), 32'd0);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
`endif
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            stall  = run_vec[i].stall;
            halt   = run_vec[i].halt;
            resume = run_vec[i].resume;
            #1;
            chk($sformatf("run%0d_state", i), 32'(state), 32'(run_vec[i].exp_state));
            chk($sformatf("run%0d_pc_en", i), 32'(pc_en), 32'(run_vec[i].exp_pc_en));
            chk($sformatf("run%0d_fv", i), 32'(fetch_valid), 32'(run_vec[i].exp_fv));
            chk($sformatf("run%0d_ready", i), 32'(ld_ready), 32'd0);
            @(negedge clk);
        end
        stall = 1'b0; halt = 1'b0; resume = 1'b0;

        // Asynchronous reset while running, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_run_state", 32'(state), 32'd0);
        chk("arst_run_pc_en", 32'(pc_en), 32'd0);
        chk("arst_run_fv", 32'(fetch_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            ldr_en    = ldr_vec[i].en;
            ldr_valid = ldr_vec[i].valid;
            ldr_data  = ldr_vec[i].data;
            ldr_last  = ldr_vec[i].last;
            #1;
            chk($sformatf("ldr%0d_ready", i), 32'(ldr_ready), 32'(ldr_vec[i].en));
            chk($sformatf("ldr%0d_we", i), 32'(ldr_we), 32'(ldr_vec[i].exp_we));
            chk($sformatf("ldr%0d_addr", i), 32'(ldr_addr), 32'(ldr_vec[i].exp_addr));
            chk($sformatf("ldr%0d_wdata", i), ldr_wdata, ldr_vec[i].exp_wdata);
            chk($sformatf("ldr%0d_cnt", i), 32'(ldr_count), 32'(ldr_vec[i].exp_cnt));
            chk($sformatf("ldr%0d_done", i), 32'(ldr_done), 32'(ldr_vec[i].exp_done));
            chk($sformatf("ldr%0d_ovf", i), 32'(ldr_ovf), 32'(ldr_vec[i].exp_ovf));
            @(negedge clk);
        end
        ldr_en = 1'b0; ldr_valid = 1'b0; ldr_last = 1'b0;

        // Last marker on the final memory word: complete, but no overflow.
        do_reset();
        ldr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ldr_valid = 1'b1;
            ldr_data  = img[i];
            ldr_last  = (i == 3);
            #1;
            chk("ldrcap_done", 32'(ldr_done), 32'(i == 3));
            @(negedge clk);
        end
        ldr_en = 1'b0; ldr_valid = 1'b0; ldr_last = 1'b0;
        #1;
        chk("ldrcap_ovf", 32'(ldr_ovf), 32'd0);
        chk("ldrcap_cnt", 32'(ldr_count), 32'd4);

`ifdef FETCH_CTRL_BOOTLOAD_EN
        // Loader gap of 5 cycles mid-image.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            int w;
            w = (i < 2) ? i : i - 5;
            ld_valid = (i < 2) || (i >= 7);
            ld_data  = (i < 2 || i >= 7) ? img[w] : 32'hDEADBEEF;
            ld_last  = (i == 8);
            #1;
            if (i >= 2 && i < 7) begin
                chk("gap_we", 32'(mem_we), 32'd0);
                chk("gap_state", 32'(state), 32'd1);
            end else begin
                chk("gap_addr", 32'(mem_addr), 32'(w * 4));
                chk("gap_we_on", 32'(mem_we), 32'd1);
            end
            @(negedge clk);
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        chk("gap_run", 32'(state), 32'd2);
        chk("gap_count", 32'(ld_count), 32'd4);

        // Overflow on a 4-word memory with a 6-word image.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'h100 + 32'(i);
            ld_last  = 1'b0;
            #1;
            if (i < 4) begin
                chk("ovf_we", 32'(mem_we4), 32'd1);
                chk("ovf_addr", 32'(mem_addr4), 32'(i * 4));
            end else begin
                chk("ovf_we_rej", 32'(mem_we4), 32'd0);
                chk("ovf_ready_rej", 32'(ld_ready4), 32'd0);
                chk("ovf_state", 32'(state4), 32'd2);
            end
            @(negedge clk);
        end
        ld_valid = 1'b0;
        #1;
        chk("ovf_flag", 32'(ld_ovf4), 32'd1);
        chk("ovf_count", 32'(ld_count4), 32'd4);

        // Asynchronous reset after two load words.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = img[i];
            @(negedge clk);
        end
        ld_data = img[2];
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ld_state", 32'(state), 32'd0);
        chk("arst_ld_count", 32'(ld_count), 32'd0);
        chk("arst_ld_ready", 32'(ld_ready), 32'd0);
        chk("arst_ld_we", 32'(mem_we), 32'd0);
        chk("arst_ld_addr", 32'(mem_addr), 32'd0);
        chk("arst_ld_wdata", mem_wdata, 32'd0);
        chk("arst_ld_ovf", 32'(ld_ovf), 32'd0);
        ld_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = img[0];
        #1;
        chk("arst_reload_state", 32'(state), 32'd1);
        chk("arst_reload_addr", 32'(mem_addr), 32'd0);
        chk("arst_reload_we", 32'(mem_we), 32'd1);
        @(negedge clk);
        ld_valid = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: MEM_WORDS, default 2048, instruction memory depth in 32-bit words (byte address width 13).
REQ-002 Parameter: LD_CNT_W, default 12, width of the load word counter; SHALL satisfy 2**LD_CNT_W > MEM_WORDS.
REQ-003 i_clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 i_rst  in  1  asynchronous, active-low reset.
REQ-005 i_ld_valid  in  1  loader word valid.
REQ-006 i_ld_data  in  32  loader instruction word.
REQ-007 i_ld_last  in  1  final word of the image, qualified by i_ld_valid.
REQ-008 o_ld_ready  out  1  controller accepts a loader word.
REQ-009 o_mem_we  out  1  instruction memory write enable.
REQ-010 o_mem_addr  out  13  instruction memory write byte address.
REQ-011 o_mem_wdata  out  32  instruction memory write data.
REQ-012 i_stall  in  1  datapath stall request.
REQ-013 i_halt  in  1  halt request from decode (ebreak or illegal instruction).
REQ-014 i_resume  in  1  leave HALT.
REQ-015 o_pc_en  out  1  PC update enable for the PC generator.
REQ-016 o_fetch_valid  out  1  fetched instruction valid; 0 forces a NOP into decode.
REQ-017 o_state  out  2  FSM state: 0 IDLE, 1 LOAD, 2 RUN, 3 HALT.
REQ-018 o_ld_count  out  LD_CNT_W  number of words written in the current load.
REQ-019 o_ld_ovf  out  1  sticky flag: the image exceeded MEM_WORDS.

Function
REQ-020 IDLE SHALL last exactly one cycle after reset release, then go to LOAD.
REQ-021 In LOAD, o_ld_ready SHALL be 1; it SHALL be 0 in every other state.
REQ-022 A transfer SHALL occur on a cycle with i_ld_valid and o_ld_ready both 1.
REQ-023 On a transfer, o_mem_we SHALL be 1 combinationally, with o_mem_addr = o_ld_count*4 (low 13 bits) and o_mem_wdata = i_ld_data; o_ld_count SHALL increment by 1.
REQ-024 A transfer with i_ld_last = 1 SHALL move the FSM to RUN on the next cycle.
REQ-025 A transfer that writes word MEM_WORDS-1 without i_ld_last SHALL move the FSM to RUN and set o_ld_ovf; loader words after that are not accepted.
REQ-026 When i_ld_valid = 0 in LOAD, the FSM SHALL hold LOAD with o_mem_we = 0; there is no timeout.
REQ-027 In RUN, o_fetch_valid SHALL be 1 and o_pc_en SHALL equal ~i_stall.
REQ-028 i_halt = 1 in RUN SHALL force o_pc_en = 0 in that cycle and move the FSM to HALT on the next cycle; i_halt takes priority over i_stall.
REQ-029 In HALT, o_pc_en and o_fetch_valid SHALL be 0.
REQ-030 i_resume = 1 in HALT SHALL move the FSM to RUN on the next cycle; i_resume SHALL be ignored in all other states.
REQ-031 In IDLE and LOAD, o_pc_en, o_fetch_valid and o_mem_we (outside transfers) SHALL be 0.

Reset
REQ-032 Asserting i_rst SHALL immediately, without a clock, set: state IDLE, o_ld_count 0, o_ld_ovf 0, o_pc_en 0, o_fetch_valid 0, o_ld_ready 0, o_mem_we 0, o_mem_addr 0, o_mem_wdata 0.
REQ-033 Reset asserted in the middle of a load SHALL abort the load; the next load SHALL restart at address 0.

Configuration
REQ-034 With FETCH_CTRL_BOOTLOAD_EN defined, the FSM SHALL follow the IDLE -> LOAD -> RUN sequence above.
REQ-035 Without FETCH_CTRL_BOOTLOAD_EN, IDLE SHALL go directly to RUN and LOAD SHALL be unreachable; o_ld_ready, o_mem_we, o_ld_count and o_ld_ovf SHALL be tied to 0, and the memory image is preloaded.

Structure
REQ-036 Package fetch_ctrl_pkg SHALL hold the 2-bit state enum type (IDLE, LOAD, RUN, HALT) and the MEM_WORDS default constant.
REQ-037 The loader path (counter, address generation, overflow flag) SHALL be one sub-module, fetch_loader; the FSM and run/halt control SHALL stay in fetch_ctrl.

Verification
REQ-038 Reset, then 3 words 0x00000013, 0x00100093, 0x00000073 with last on the third: o_mem_addr is 0x000, 0x004, 0x008; RUN one cycle later; o_ld_count = 3.
REQ-039 Loader drops i_ld_valid for 5 cycles mid-image: o_mem_we is 0 during the gap and addresses stay contiguous.
REQ-040 MEM_WORDS = 4 and 6 words sent: 4 writes, last at o_mem_addr 0x00C; o_ld_ovf = 1; RUN entered; words 5 and 6 not accepted.
REQ-041 In RUN, i_stall and i_halt high in the same cycle: o_pc_en = 0; HALT next cycle; i_resume pulse returns to RUN with o_pc_en = 1.
REQ-042 i_rst asserted asynchronously after 2 load words: all outputs reset with no clock edge; the next load starts at address 0x000.
REQ-043 Build without FETCH_CTRL_BOOTLOAD_EN: o_state goes 0 -> 2 one cycle after reset release; o_ld_ready stays 0.
